alu_shift_seq: RTL
==================

# alu_shift_seq

Multi-cycle sequencer for the single-step shift/swap ALU unit, which performs one logical right shift, or one nibble swap, per bus transfer. The block holds the operand in an internal working register and drives it as the unit's left argument. Each cycle it enables the unit's bus and flag outputs and captures the shifted byte and carry-out back into the register. This builds LSR, ROR and ASR by 0–7 positions plus SWAP from repeated single-bit passes, and reports a result byte, carry flag and completion pulse to the control logic.

## Interface
Parameters:
- none (datapath fixed at 8 bits, count fixed at 3 bits)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 LSR, 01 ROR, 10 ASR, 11 SWAP
- cnt  in  3  shift count 0–7; ignored for SWAP
- din  in  8  operand, latched with start
- sh_arg  out  8  working register, to unit left argument
- sh_cin  out  1  bit shifted into position 7, to unit carry-in
- sh_fn_swap  out  1  unit function select; 1 = nibble swap
- sh_outn  out  1  unit output enable, active low
- sh_bus  in  8  unit result byte
- sh_cout  in  1  unit carry-out (bit 0 of sh_arg)
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- result  out  8  equals sh_arg; valid when done=1 and thereafter until next start
- carry  out  1  carry flag of last completed operation

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1, latch din into sh_arg, latch op, and load remaining = (op==SWAP) ? 1 : cnt. Clear carry.
  - Next state is SHIFT if remaining≠0, otherwise DONE.
  - With start=0, stay in IDLE.
- SHIFT:
  - sh_outn=0.
  - Every edge: sh_arg ← sh_bus, carry ← sh_cout, remaining ← remaining−1.
  - When remaining==1 at the edge, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - start is ignored in DONE.
- sh_cin is combinational from op and the current sh_arg:
  - LSR: 0
  - ROR: sh_arg[0]
  - ASR: sh_arg[7]
  - SWAP: 0
- sh_fn_swap = 1 only in SHIFT with op==SWAP; 0 otherwise.
- sh_outn = 1 in IDLE and DONE, so the unit never drives the shared bus outside SHIFT.
- Carry rules:
  - For shifts with cnt≥1, carry ends as original bit (cnt−1).
  - For cnt=0, carry=0.
  - For SWAP, carry ← sh_cout of the swap pass, which is original bit 0. The unit's flag path is independent of fn_swap.
- busy = 1 in SHIFT, 0 in IDLE and DONE.
- start while busy or in DONE is dropped, not queued.
- op, cnt and din changing after the start cycle have no effect.

## Timing
- Start sampled at edge E0. SHIFT occupies the N cycles after E0, where N = cnt for shifts and N = 1 for SWAP. done is high during cycle N+1 after E0.
- cnt=0: no SHIFT cycles. done is high in the cycle after E0, with result = din and carry = 0.
- The earliest new start is accepted at the edge that ends the done cycle plus one. Minimum spacing is N+2 cycles.
- The unit is combinational: sh_bus and sh_cout must be settled within the same SHIFT cycle in which they are captured.
- Reset, asynchronous, at any time including mid-SHIFT:
  - State → IDLE.
  - sh_arg=0x00, carry=0, remaining=0.
  - done=0, busy=0, sh_outn=1, sh_fn_swap=0.
  - No partial result is retained.
- Release of reset takes effect at the next rising edge. A start asserted on that edge is accepted.

## Test plan
- LSR: op=00, cnt=3, din=0xB5 → busy high 3 cycles; done in cycle 4 after start; result=0x16, carry=1.
- ROR: op=01, cnt=1, din=0x01 → result=0x80, carry=1. Then op=01, cnt=7, din=0xA5 → result=0x4B, carry=0, done 8 cycles after start.
- ASR: op=10, cnt=2, din=0x84 → result=0xE1, carry=0. sh_cin=1 in both SHIFT cycles.
- SWAP and zero count:
  - op=11, din=0x3C, cnt=5 → exactly one SHIFT cycle with sh_fn_swap=1; result=0xC3, carry=0.
  - op=00, cnt=0, din=0x5A → done the cycle after start, result=0x5A, carry=0, sh_outn never low.
- Start filtering: start held high continuously, op=00, cnt=2, din changing every cycle → only the IDLE-sampled din is used; operations repeat with a spacing of 4 cycles; done is never two cycles wide.
- Reset mid-op: op=01, cnt=6, din=0xFF; assert rst in the 3rd SHIFT cycle → outputs immediately at reset values (sh_arg=0x00, carry=0, busy=0, done=0, sh_outn=1). After release, a new start with op=00, cnt=1, din=0x02 gives result=0x01, carry=0.

Source files
------------

// File: rtl/alu_shift_seq.sv
// Sequencer that builds multi-bit LSR/ROR/ASR and SWAP from repeated single-step
// passes through an external combinational shift/swap unit.
module alu_shift_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [2:0] cnt,
    input  logic [7:0] din,
    output logic [7:0] sh_arg,
    output logic       sh_cin,
    output logic       sh_fn_swap,
    output logic       sh_outn,
    input  logic [7:0] sh_bus,
    input  logic       sh_cout,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       carry
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LSR  = 2'b00;
    localparam logic [1:0] OP_ROR  = 2'b01;
    localparam logic [1:0] OP_ASR  = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] arg_reg;
    logic [1:0] op_reg;
    logic [2:0] remaining_reg;
    logic       carry_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Working register, latched opcode, pass counter and carry flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arg_reg       <= 8'h00;
            op_reg        <= OP_LSR;
            remaining_reg <= 3'd0;
            carry_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        arg_reg       <= din;
                        op_reg        <= op;
                        remaining_reg <= (op == OP_SWAP) ? 3'd1 : cnt;
                        carry_reg     <= 1'b0;
                    end
                end
                SHIFT: begin
                    arg_reg       <= sh_bus;
                    carry_reg     <= sh_cout;
                    remaining_reg <= remaining_reg - 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = ((op == OP_SWAP) || (cnt != 3'd0)) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (remaining_reg <= 3'd1) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        sh_outn    = 1'b1;
        sh_fn_swap = 1'b0;
        case (state_reg)
            SHIFT: begin
                busy       = 1'b1;
                sh_outn    = 1'b0;
                sh_fn_swap = (op_reg == OP_SWAP);
            end
            DONE:    done = 1'b1;
            default: begin
            end
        endcase
    end

    // Bit fed into position 7 selects logical, rotate or arithmetic behaviour.
    always_comb begin
        sh_cin = 1'b0;
        case (op_reg)
            OP_ROR:  sh_cin = arg_reg[0];
            OP_ASR:  sh_cin = arg_reg[7];
            default: sh_cin = 1'b0;
        endcase
    end

    assign sh_arg = arg_reg;
    assign result = arg_reg;
    assign carry  = carry_reg;

endmodule
